// File: rtl/apb_initiator_bridge_pkg.sv
// Shared types for the req/gnt to APB4 initiator bridge: FSM state encoding
// and the registered upstream request.
package apb_initiator_pkg;

  localparam int unsigned REQ_ADDR_W = 32;
  localparam int unsigned REQ_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_init_state_e;

  typedef struct packed {
    logic [REQ_ADDR_W-1:0]   addr;
    logic                    we;
    logic [REQ_DATA_W/8-1:0] be;
    logic [REQ_DATA_W-1:0]   wdata;
  } req_t;

endpackage

// File: rtl/apb_initiator_bridge_timeout_counter.sv
// ACCESS-phase wait counter: cleared before each ACCESS phase, saturating,
// flags the last allowed cycle. TIMEOUT_CYCLES=0 never expires.
module apb_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned   CW       = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

endmodule

// File: rtl/apb_initiator_bridge.sv
// Single-outstanding req/gnt/r_valid port to APB4 initiator, with a per-transfer
// timeout that aborts a hung ACCESS phase and sets a sticky timeout flag.
module apb_initiator_bridge
  import apb_initiator_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = REQ_ADDR_W,
  parameter int unsigned APB_DATA_WIDTH = REQ_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_i,
  output logic                        gnt_o,
  input  logic [APB_ADDR_WIDTH-1:0]   addr_i,
  input  logic                        we_i,
  input  logic [APB_DATA_WIDTH/8-1:0] be_i,
  input  logic [APB_DATA_WIDTH-1:0]   wdata_i,
  output logic                        r_valid_o,
  output logic [APB_DATA_WIDTH-1:0]   r_rdata_o,
  output logic                        r_err_o,
  output logic                        timeout_o,
  output logic [APB_ADDR_WIDTH-1:0]   paddr_o,
  output logic [APB_DATA_WIDTH-1:0]   pwdata_o,
  output logic                        pwrite_o,
  output logic [APB_DATA_WIDTH/8-1:0] pstrb_o,
  output logic                        psel_o,
  output logic                        penable_o,
  input  logic                        pready_i,
  input  logic [APB_DATA_WIDTH-1:0]   prdata_i,
  input  logic                        pslverr_i
);

  apb_init_state_e           r_state;
  req_t                      r_req;
  logic                      r_psel;
  logic                      r_penable;
  logic                      r_valid;
  logic                      r_err;
  logic                      r_timeout;
  logic [APB_DATA_WIDTH-1:0] r_rdata;

  logic w_accept;
  logic w_cnt_clr;
  logic w_cnt_en;
  logic w_expire;

  // Grant is only offered when no transfer is in flight on the APB side.
  assign w_accept  = req_i && ((r_state == IDLE) || (r_state == RESP));
  assign w_cnt_clr = (r_state == SETUP);
  assign w_cnt_en  = (r_state == ACCESS) && !pready_i;

  apb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_expire(w_expire)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_req     <= '0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE, RESP: begin
          if (w_accept) begin
            r_req   <= '{addr: addr_i, we: we_i, be: (we_i ? be_i : '0), wdata: wdata_i};
            r_psel  <= 1'b1;
            r_state <= SETUP;
          end else begin
            r_state <= IDLE;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          // pready takes priority over an expiring count in the same cycle.
          if (pready_i) begin
            r_rdata   <= r_req.we ? '0 : prdata_i;
            r_err     <= pslverr_i;
            r_valid   <= 1'b1;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_state   <= RESP;
          end else if (w_expire) begin
            r_rdata   <= '0;
            r_err     <= 1'b1;
            r_timeout <= 1'b1;
            r_valid   <= 1'b1;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_state   <= RESP;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt_o     = w_accept;
  assign r_valid_o = r_valid;
  assign r_rdata_o = r_rdata;
  assign r_err_o   = r_err;
  assign timeout_o = r_timeout;
  assign paddr_o   = r_req.addr;
  assign pwdata_o  = r_req.wdata;
  assign pwrite_o  = r_req.we;
  assign pstrb_o   = r_req.be;
  assign psel_o    = r_psel;
  assign penable_o = r_penable;

endmodule

// File: tb/tb_apb_initiator_bridge.sv
// Directed bench: one bridge with the default timeout, one with TIMEOUT_CYCLES=4.
module tb_apb_initiator_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, req2;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        pready, pready2;
  logic [31:0] prdata;
  logic        pslverr;

  logic        gnt, r_valid, r_err, timeout, pwrite, psel, penable;
  logic [31:0] r_rdata, paddr, pwdata;
  logic [3:0]  pstrb;

  logic        gnt2, r_valid2, r_err2, timeout2, pwrite2, psel2, penable2;
  logic [31:0] r_rdata2, paddr2, pwdata2;
  logic [3:0]  pstrb2;

  int checks = 0;
  int errors = 0;

  logic [31:0] vals [3];

  always #5 clk = ~clk;

  apb_initiator_bridge dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .r_valid_o(r_valid), .r_rdata_o(r_rdata), .r_err_o(r_err),
    .timeout_o(timeout), .paddr_o(paddr), .pwdata_o(pwdata), .pwrite_o(pwrite),
    .pstrb_o(pstrb), .psel_o(psel), .penable_o(penable), .pready_i(pready),
    .prdata_i(prdata), .pslverr_i(pslverr)
  );

  apb_initiator_bridge #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req2), .gnt_o(gnt2), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .r_valid_o(r_valid2), .r_rdata_o(r_rdata2), .r_err_o(r_err2),
    .timeout_o(timeout2), .paddr_o(paddr2), .pwdata_o(pwdata2), .pwrite_o(pwrite2),
    .pstrb_o(pstrb2), .psel_o(psel2), .penable_o(penable2), .pready_i(pready2),
    .prdata_i(prdata), .pslverr_i(pslverr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    vals[0] = 32'h1111_1111;
    vals[1] = 32'h2222_2222;
    vals[2] = 32'h3333_3333;
    rst_n = 1'b0; req = 1'b0; req2 = 1'b0; addr = '0; we = 1'b0; be = '0; wdata = '0;
    pready = 1'b0; pready2 = 1'b0; prdata = '0; pslverr = 1'b0;

    // Reset state
    cyc(); cyc();
    #1;
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_rvalid", r_valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_rdata", r_rdata, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_psel2", psel2, 0);
    rst_n = 1'b1;
    cyc();

    // 1: zero-wait read
    req = 1'b1; we = 1'b0; addr = 32'h1A10_0000; #1;
    chk("t1_gnt_c0", gnt, 1);
    chk("t1_psel_c0", psel, 0);
    cyc(); req = 1'b0; #1;
    chk("t1_psel_c1", psel, 1);
    chk("t1_penable_c1", penable, 0);
    chk("t1_gnt_c1", gnt, 0);
    chk("t1_paddr_c1", paddr, 32'h1A10_0000);
    chk("t1_pstrb_rd", pstrb, 0);
    cyc(); pready = 1'b1; prdata = 32'hCAFE_F00D; #1;
    chk("t1_psel_c2", psel, 1);
    chk("t1_penable_c2", penable, 1);
    chk("t1_rvalid_c2", r_valid, 0);
    cyc(); pready = 1'b0; prdata = '0; #1;
    chk("t1_rvalid_c3", r_valid, 1);
    chk("t1_rdata_c3", r_rdata, 32'hCAFE_F00D);
    chk("t1_err_c3", r_err, 0);
    chk("t1_psel_c3", psel, 0);
    cyc(); #1;
    chk("t1_rvalid_c4", r_valid, 0);
    chk("t1_rdata_hold", r_rdata, 32'hCAFE_F00D);

    // 2: write with 5 wait states; APB signals stable while inputs change
    req = 1'b1; we = 1'b1; addr = 32'h1A10_1004; be = 4'b0110; wdata = 32'h1234_5678; #1;
    chk("t2_gnt", gnt, 1);
    cyc(); req = 1'b0; addr = '0; be = '0; wdata = '0; we = 1'b0; #1;
    chk("t2_setup_psel", psel, 1);
    chk("t2_setup_penable", penable, 0);
    for (int i = 0; i < 6; i++) begin
      chk("t2_paddr", paddr, 32'h1A10_1004);
      chk("t2_pstrb", pstrb, 4'b0110);
      chk("t2_pwdata", pwdata, 32'h1234_5678);
      chk("t2_pwrite", pwrite, 1);
      chk("t2_rvalid_wait", r_valid, 0);
      cyc();
      if (i == 5) begin
        pready = 1'b1; prdata = 32'hDEAD_BEEF;
      end
      #1;
      chk("t2_penable", penable, 1);
    end
    chk("t2_paddr_last", paddr, 32'h1A10_1004);
    chk("t2_pstrb_last", pstrb, 4'b0110);
    cyc(); pready = 1'b0; prdata = '0; #1;
    chk("t2_rvalid", r_valid, 1);
    chk("t2_rdata_zero", r_rdata, 0);
    chk("t2_err", r_err, 0);
    cyc(); #1;
    chk("t2_rvalid_off", r_valid, 0);

    // 3: read with slave error
    req = 1'b1; we = 1'b0; addr = 32'h1A10_2000; #1;
    chk("t3_gnt", gnt, 1);
    cyc(); req = 1'b0; #1;
    cyc(); pready = 1'b1; pslverr = 1'b1; prdata = 32'h55AA_55AA; #1;
    cyc(); pready = 1'b0; pslverr = 1'b0; prdata = '0; #1;
    chk("t3_rvalid", r_valid, 1);
    chk("t3_err", r_err, 1);
    chk("t3_rdata", r_rdata, 32'h55AA_55AA);
    chk("t3_timeout", timeout, 0);
    cyc(); #1;
    chk("t3_timeout_after", timeout, 0);

    // 4: timeout with TIMEOUT_CYCLES=4, then pready on the expiring cycle
    req2 = 1'b1; we = 1'b0; addr = 32'h1A10_3000; wdata = 32'hA5A5_A5A5; #1;
    chk("t4_gnt2", gnt2, 1);
    chk("t4_gnt_other", gnt, 0);
    cyc(); req2 = 1'b0; #1;
    chk("t4_setup_psel2", psel2, 1);
    chk("t4_setup_penable2", penable2, 0);
    chk("t4_paddr2", paddr2, 32'h1A10_3000);
    chk("t4_pstrb2", pstrb2, 0);
    chk("t4_pwrite2", pwrite2, 0);
    chk("t4_pwdata2", pwdata2, 32'hA5A5_A5A5);
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      chk("t4_access_psel2", psel2, 1);
      chk("t4_access_penable2", penable2, 1);
      chk("t4_access_rvalid2", r_valid2, 0);
    end
    cyc(); #1;
    chk("t4_rvalid2", r_valid2, 1);
    chk("t4_err2", r_err2, 1);
    chk("t4_timeout2", timeout2, 1);
    chk("t4_psel2_drop", psel2, 0);
    chk("t4_penable2_drop", penable2, 0);
    chk("t4_rdata2_zero", r_rdata2, 0);
    cyc(); #1;
    chk("t4_rvalid2_off", r_valid2, 0);
    chk("t4_timeout2_sticky", timeout2, 1);
    req2 = 1'b1; #1;
    cyc(); req2 = 1'b0; #1;
    cyc(); cyc(); cyc(); #1;
    chk("t4b_psel2_access3", psel2, 1);
    cyc(); pready2 = 1'b1; prdata = 32'h7777_0000; #1;
    cyc(); pready2 = 1'b0; prdata = '0; #1;
    chk("t4b_rvalid2", r_valid2, 1);
    chk("t4b_err2", r_err2, 0);
    chk("t4b_rdata2", r_rdata2, 32'h7777_0000);
    chk("t4b_timeout2_sticky", timeout2, 1);
    cyc(); #1;

    // 5: held request, three back-to-back reads
    req = 1'b1; we = 1'b0; addr = 32'h1A10_4000;
    for (int k = 0; k < 3; k++) begin
      pready = 1'b0; prdata = '0; #1;
      chk("t5_gnt_grant", gnt, 1);
      if (k > 0) begin
        chk("t5_rvalid", r_valid, 1);
        chk("t5_rdata", r_rdata, vals[k-1]);
      end
      cyc();
      if (k == 2) req = 1'b0;
      #1;
      chk("t5_gnt_setup", gnt, 0);
      chk("t5_rvalid_setup", r_valid, 0);
      chk("t5_psel_setup", psel, 1);
      cyc(); pready = 1'b1; prdata = vals[k]; #1;
      chk("t5_gnt_access", gnt, 0);
      chk("t5_penable_access", penable, 1);
      cyc();
    end
    pready = 1'b0; prdata = '0; #1;
    chk("t5_rvalid_last", r_valid, 1);
    chk("t5_rdata_last", r_rdata, vals[2]);
    chk("t5_gnt_last", gnt, 0);
    cyc(); #1;
    chk("t5_rvalid_done", r_valid, 0);
    chk("t5_psel_done", psel, 0);

    // 6: reset during ACCESS, then a clean read
    req = 1'b1; we = 1'b0; addr = 32'h1A10_5000; #1;
    cyc(); req = 1'b0; #1;
    cyc(); #1;
    chk("t6_penable_pre", penable, 1);
    rst_n = 1'b0; pready = 1'b1; prdata = 32'h0BAD_0BAD;
    cyc(); rst_n = 1'b1; pready = 1'b0; prdata = '0; #1;
    chk("t6_psel", psel, 0);
    chk("t6_penable", penable, 0);
    chk("t6_rvalid", r_valid, 0);
    chk("t6_rdata", r_rdata, 0);
    chk("t6_timeout2_cleared", timeout2, 0);
    cyc(); #1;
    chk("t6_rvalid_after", r_valid, 0);
    req = 1'b1; addr = 32'h1A10_6000; #1;
    chk("t6_gnt_idle", gnt, 1);
    cyc(); req = 1'b0; #1;
    chk("t6_psel_setup", psel, 1);
    chk("t6_paddr", paddr, 32'h1A10_6000);
    cyc(); pready = 1'b1; prdata = 32'h0BAD_C0DE; #1;
    cyc(); pready = 1'b0; prdata = '0; #1;
    chk("t6_rvalid_new", r_valid, 1);
    chk("t6_rdata_new", r_rdata, 32'h0BAD_C0DE);
    chk("t6_err_new", r_err, 0);
    cyc(); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
